parking_gate_arbiter: RTL and testbench

Shares the parking controller's token check and slot allocation among several entry gates. Entry requests are arbitrated round-robin. The granted gate's token is compared against the system token, and on success the lowest free slot is allocated and its entry time recorded. Exit requests release slots independently and report parked duration, which feeds the fee datapath.

---
 rtl/parking_gate_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// parking_gate_arbiter
//
// Shares one token check and one slot allocator among several entry gates.
// Entry requests are arbitrated round-robin. The winning gate's token is
// compared with the system token. On a match, and if the lot is not full, the
// lowest free slot is allocated and its entry time is recorded. Exit strobes
// release slots independently of the entry FSM and report the parked duration.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   req            per-gate entry request (level, held until ack)
//   user_token     gate g token on bits [3g+2:3g]
//   system_token   valid token
//   time_now       free-running time stamp
//   exit_req       one-cycle exit strobe
//   exit_slot      slot being vacated
//   grant          one-hot owner of the current entry transaction
//   ack            one-cycle response strobe to the granted gate
//   ack_ok         entry accepted (valid with ack)
//   ack_full       entry rejected because the lot is full (valid with ack)
//   slot_id        allocated slot (valid with ack && ack_ok)
//   free_count     number of free slots
//   full           free_count == 0
//   exit_done      one-cycle strobe: exit accepted
//   exit_err       one-cycle strobe: exit on a free slot
//   exit_duration  parked time (valid with exit_done)
// -----------------------------------------------------------------------------
module parking_gate_arbiter #(
   parameter int NUM_GATES = 4,
   parameter int NUM_SLOTS = 8,
   parameter int TIME_W    = 8,
   localparam int SLOT_W   = $clog2(NUM_SLOTS),
   localparam int GATE_W   = $clog2(NUM_GATES)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_GATES-1:0]   req,
   input  logic [3*NUM_GATES-1:0] user_token,
   input  logic [2:0]             system_token,
   input  logic [TIME_W-1:0]      time_now,
   input  logic                   exit_req,
   input  logic [SLOT_W-1:0]      exit_slot,
   output logic [NUM_GATES-1:0]   grant,
   output logic                   ack,
   output logic                   ack_ok,
   output logic                   ack_full,
   output logic [SLOT_W-1:0]      slot_id,
   output logic [SLOT_W:0]        free_count,
   output logic                   full,
   output logic                   exit_done,
   output logic                   exit_err,
   output logic [TIME_W-1:0]      exit_duration
);

   localparam logic [GATE_W:0]   GATE_COUNT = (GATE_W+1)'(NUM_GATES);
   localparam logic [GATE_W-1:0] LAST_GATE  = GATE_W'(NUM_GATES-1);
   localparam logic [SLOT_W:0]   SLOT_COUNT = (SLOT_W+1)'(NUM_SLOTS);

   typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESP = 2'd2} state_t;

   state_t                state, state_next;
   logic [GATE_W-1:0]     rr_ptr, rr_ptr_next;
   logic [GATE_W-1:0]     winner, winner_next;
   logic [GATE_W-1:0]     pick;
   logic                  pick_valid;
   logic [GATE_W:0]       cand;
   logic [NUM_SLOTS-1:0]  occ, occ_next;
   logic [TIME_W-1:0]     entry_time [NUM_SLOTS];
   logic [NUM_GATES-1:0]  token_match;
   logic [NUM_GATES-1:0]  grant_next;
   logic                  ack_next, ack_ok_next, ack_full_next;
   logic [SLOT_W-1:0]     slot_id_next, free_idx;
   logic [SLOT_W:0]       free_count_next;
   logic                  alloc, exit_hit, exit_miss;

   // Per-gate token comparison against the system token.
   generate
      for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_token
         assign token_match[gi] = (user_token[3*gi +: 3] == system_token);
      end
   endgenerate

   // Round-robin search upward from rr_ptr. Offsets are scanned from the
   // largest down so the last hit is the one closest to rr_ptr.
   always_comb begin
      pick_valid = 1'b0;
      pick       = rr_ptr;
      cand       = '0;
      for (int i = NUM_GATES - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + (GATE_W+1)'(i);
         if (cand >= GATE_COUNT) cand = cand - GATE_COUNT;
         if (req[cand[GATE_W-1:0]]) begin
            pick_valid = 1'b1;
            pick       = cand[GATE_W-1:0];
         end
      end
   end

   // Lowest-index free slot in the registered occupancy.
   always_comb begin
      free_idx = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (!occ[s]) free_idx = SLOT_W'(s);
      end
   end

   assign exit_hit  = exit_req &  occ[exit_slot];
   assign exit_miss = exit_req & ~occ[exit_slot];

   // Entry FSM next-state and response logic.
   always_comb begin
      state_next    = state;
      rr_ptr_next   = rr_ptr;
      winner_next   = winner;
      grant_next    = grant;
      ack_next      = 1'b0;
      ack_ok_next   = ack_ok;
      ack_full_next = ack_full;
      slot_id_next  = slot_id;
      alloc         = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               winner_next      = pick;
               grant_next       = '0;
               grant_next[pick] = 1'b1;
               state_next       = CHECK;
            end
         end
         CHECK: begin
            ack_next   = 1'b1;
            state_next = RESP;
            if (!token_match[winner]) begin
               ack_ok_next   = 1'b0;
               ack_full_next = 1'b0;
            end else if (free_count == '0) begin
               ack_ok_next   = 1'b0;
               ack_full_next = 1'b1;
            end else begin
               ack_ok_next   = 1'b1;
               ack_full_next = 1'b0;
               slot_id_next  = free_idx;
               alloc         = 1'b1;
            end
         end
         RESP: begin
            state_next  = IDLE;
            grant_next  = '0;
            rr_ptr_next = (winner == LAST_GATE) ? '0 : winner + 1'b1;
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   // Occupancy update. Allocation chose its slot from the pre-exit occupancy,
   // so a slot vacated in this same cycle cannot be the one allocated, and the
   // two updates never touch the same bit.
   always_comb begin
      occ_next = occ;
      if (exit_hit) occ_next[exit_slot] = 1'b0;
      if (alloc)    occ_next[free_idx]  = 1'b1;
      free_count_next = free_count + (SLOT_W+1)'(exit_hit) - (SLOT_W+1)'(alloc);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         winner        <= '0;
         occ           <= '0;
         grant         <= '0;
         ack           <= 1'b0;
         ack_ok        <= 1'b0;
         ack_full      <= 1'b0;
         slot_id       <= '0;
         free_count    <= SLOT_COUNT;
         full          <= 1'b0;
         exit_done     <= 1'b0;
         exit_err      <= 1'b0;
         exit_duration <= '0;
         for (int s = 0; s < NUM_SLOTS; s++) entry_time[s] <= '0;
      end else begin
         state      <= state_next;
         rr_ptr     <= rr_ptr_next;
         winner     <= winner_next;
         occ        <= occ_next;
         grant      <= grant_next;
         ack        <= ack_next;
         ack_ok     <= ack_ok_next;
         ack_full   <= ack_full_next;
         slot_id    <= slot_id_next;
         free_count <= free_count_next;
         full       <= (free_count_next == '0);
         exit_done  <= exit_hit;
         exit_err   <= exit_miss;
         if (alloc)    entry_time[free_idx] <= time_now;
         // Modular subtraction handles time stamp wrap-around.
         if (exit_hit) exit_duration <= time_now - entry_time[exit_slot];
      end
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_arbiter
//
// Self-checking bench for parking_gate_arbiter (4 gates, 8 slots, 8-bit time).
// Expected entry and exit responses are pushed to queues when stimulus is
// driven and popped when the DUT responds. Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_parking_gate_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [11:0] user_token = '0;
   logic [2:0]  system_token = 3'b101;
   logic [7:0]  time_now = '0;
   logic        exit_req = 1'b0;
   logic [2:0]  exit_slot = '0;
   logic [3:0]  grant;
   logic        ack, ack_ok, ack_full;
   logic [2:0]  slot_id;
   logic [3:0]  free_count;
   logic        full, exit_done, exit_err;
   logic [7:0]  exit_duration;

   int compared = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [3:0] grant;
      logic       ok;
      logic       full_flag;
      logic [2:0] slot;
      logic [3:0] free;
   } entry_exp_t;

   typedef struct packed {
      logic       done;
      logic       err;
      logic [7:0] dur;
      logic [3:0] free;
   } exit_exp_t;

   entry_exp_t entry_q[$];
   exit_exp_t  exit_q[$];

   parking_gate_arbiter #(.NUM_GATES(4), .NUM_SLOTS(8), .TIME_W(8)) dut (
      .clock(clock), .reset(reset), .req(req), .user_token(user_token),
      .system_token(system_token), .time_now(time_now), .exit_req(exit_req),
      .exit_slot(exit_slot), .grant(grant), .ack(ack), .ack_ok(ack_ok),
      .ack_full(ack_full), .slot_id(slot_id), .free_count(free_count),
      .full(full), .exit_done(exit_done), .exit_err(exit_err),
      .exit_duration(exit_duration)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_token(input int g, input logic [2:0] t);
      user_token[3*g +: 3] = t;
   endtask

   // One full entry transaction from an IDLE cycle. Optionally fires an exit
   // strobe during the CHECK cycle (its expectation is pushed by the caller).
   task automatic do_entry(input string name, input logic [3:0] r, input bit keep,
                           input logic [3:0] exp_grant, input logic exp_ok,
                           input logic exp_full, input logic [2:0] exp_slot,
                           input logic [3:0] exp_free, input bit xen,
                           input logic [2:0] xslot, input logic [7:0] xtime);
      entry_exp_t e;
      exit_exp_t  x;
      e = '{grant: exp_grant, ok: exp_ok, full_flag: exp_full, slot: exp_slot, free: exp_free};
      entry_q.push_back(e);
      req = r;
      tick();
      compared++;
      if (grant !== exp_grant) begin
         mismatched++;
         $display("FAIL %s grant: got %b want %b", name, grant, exp_grant);
      end
      compared++;
      if (ack !== 1'b0) begin
         mismatched++;
         $display("FAIL %s ack_early: got %b want 0", name, ack);
      end
      if (xen) begin
         exit_req  = 1'b1;
         exit_slot = xslot;
         time_now  = xtime;
      end
      tick();
      exit_req = 1'b0;
      e = entry_q.pop_front();
      compared++;
      if (ack !== 1'b1) begin
         mismatched++;
         $display("FAIL %s ack: got %b want 1", name, ack);
      end
      compared++;
      if ({ack_ok, ack_full} !== {e.ok, e.full_flag}) begin
         mismatched++;
         $display("FAIL %s ok_full: got %b%b want %b%b", name, ack_ok, ack_full, e.ok, e.full_flag);
      end
      if (e.ok) begin
         compared++;
         if (slot_id !== e.slot) begin
            mismatched++;
            $display("FAIL %s slot_id: got %0d want %0d", name, slot_id, e.slot);
         end
      end
      compared++;
      if (free_count !== e.free) begin
         mismatched++;
         $display("FAIL %s free_count: got %0d want %0d", name, free_count, e.free);
      end
      compared++;
      if (full !== (e.free == 4'd0)) begin
         mismatched++;
         $display("FAIL %s full: got %b want %b", name, full, (e.free == 4'd0));
      end
      compared++;
      if (grant !== e.grant) begin
         mismatched++;
         $display("FAIL %s grant_held: got %b want %b", name, grant, e.grant);
      end
      if (xen) begin
         x = exit_q.pop_front();
         compared++;
         if ({exit_done, exit_err} !== {x.done, x.err}) begin
            mismatched++;
            $display("FAIL %s exit_flags: got %b%b want %b%b", name, exit_done, exit_err, x.done, x.err);
         end
         compared++;
         if (exit_duration !== x.dur) begin
            mismatched++;
            $display("FAIL %s exit_duration: got %h want %h", name, exit_duration, x.dur);
         end
      end
      $display("entry %s grant=%b ack_ok=%b ack_full=%b slot=%0d free=%0d",
               name, e.grant, ack_ok, ack_full, slot_id, free_count);
      if (!keep) req = '0;
      tick();
      compared++;
      if (ack !== 1'b0 || grant !== 4'b0000) begin
         mismatched++;
         $display("FAIL %s release: got ack=%b grant=%b want ack=0 grant=0000", name, ack, grant);
      end
   endtask

   task automatic do_exit(input string name, input logic [2:0] slot, input logic [7:0] t,
                          input logic exp_done, input logic exp_err,
                          input logic [7:0] exp_dur, input logic [3:0] exp_free);
      exit_exp_t x;
      x = '{done: exp_done, err: exp_err, dur: exp_dur, free: exp_free};
      exit_q.push_back(x);
      exit_req  = 1'b1;
      exit_slot = slot;
      time_now  = t;
      tick();
      exit_req = 1'b0;
      x = exit_q.pop_front();
      compared++;
      if ({exit_done, exit_err} !== {x.done, x.err}) begin
         mismatched++;
         $display("FAIL %s exit_flags: got %b%b want %b%b", name, exit_done, exit_err, x.done, x.err);
      end
      compared++;
      if (exit_duration !== x.dur) begin
         mismatched++;
         $display("FAIL %s exit_duration: got %h want %h", name, exit_duration, x.dur);
      end
      compared++;
      if (free_count !== x.free || full !== (x.free == 4'd0)) begin
         mismatched++;
         $display("FAIL %s free_count: got %0d full=%b want %0d", name, free_count, full, x.free);
      end
      $display("exit %s slot=%0d done=%b err=%b dur=%h free=%0d",
               name, slot, exit_done, exit_err, exit_duration, free_count);
      tick();
      compared++;
      if (exit_done !== 1'b0 || exit_err !== 1'b0) begin
         mismatched++;
         $display("FAIL %s exit_strobe_len: got done=%b err=%b want 0 0", name, exit_done, exit_err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      compared++;
      if (grant !== 4'b0000 || ack !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_grant_ack: got grant=%b ack=%b want 0000 0", grant, ack);
      end
      compared++;
      if (free_count !== 4'd8 || full !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_free: got free=%0d full=%b want 8 0", free_count, full);
      end
      compared++;
      if ({ack_ok, ack_full, slot_id, exit_done, exit_err, exit_duration} !== 15'd0) begin
         mismatched++;
         $display("FAIL reset_misc: got ok=%b full=%b slot=%0d done=%b err=%b dur=%h want all 0",
                  ack_ok, ack_full, slot_id, exit_done, exit_err, exit_duration);
      end
      $display("reset free=%0d grant=%b", free_count, grant);
      // Reset asserted during CHECK aborts the transaction.
      reset = 1'b1;
      set_token(0, 3'b101);
      req = 4'b0001;
      tick();
      compared++;
      if (grant !== 4'b0001) begin
         mismatched++;
         $display("FAIL reset_check_grant: got %b want 0001", grant);
      end
      reset = 1'b0;
      tick();
      compared++;
      if (grant !== 4'b0000 || ack !== 1'b0 || free_count !== 4'd8) begin
         mismatched++;
         $display("FAIL reset_in_check: got grant=%b ack=%b free=%0d want 0000 0 8", grant, ack, free_count);
      end
      reset = 1'b1;
      req = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         compared++;
         if (ack !== 1'b0 || free_count !== 4'd8) begin
            mismatched++;
            $display("FAIL reset_no_ack: cycle %0d got ack=%b free=%0d want 0 8", k, ack, free_count);
         end
      end
      $display("reset_in_check aborted grant=%b free=%0d", grant, free_count);
   endtask

   task automatic test_single_entry();
      system_token = 3'b101;
      set_token(0, 3'b101);
      time_now = 8'hF2;
      do_entry("single", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd0, 4'd7, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_wrong_token();
      set_token(2, 3'b011);
      do_entry("wrong_token", 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 3'd0, 4'd7, 1'b0, 3'd0, 8'h00);
      // rr_ptr is now 3: with gates 0 and 3 requesting, gate 3 must win.
      set_token(3, 3'b101);
      do_entry("rr_after_wrong", 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b0, 3'd1, 4'd6, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_round_robin();
      logic [3:0] g;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) set_token(k, 3'b101);
      g = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         time_now = 8'hED + 8'(i);
         do_entry($sformatf("rr%0d", i), 4'b1111, (i < 4), g, 1'b1, 1'b0,
                  3'(i), 4'(7 - i), 1'b0, 3'd0, 8'h00);
         g = {g[2:0], g[3]};
      end
   endtask

   task automatic test_full_lot();
      for (int i = 0; i < 3; i++) begin
         time_now = 8'h30 + 8'(i);
         do_entry($sformatf("fill%0d", i), 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0,
                  3'(5 + i), 4'(2 - i), 1'b0, 3'd0, 8'h00);
      end
      do_entry("ninth_full", 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0, 3'd0, 8'h00);
      do_exit("exit6", 3'd6, 8'h40, 1'b1, 1'b0, 8'h0F, 4'd1);
      time_now = 8'h50;
      do_entry("refill6", 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0, 3'd6, 4'd0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic test_back_to_back();
      exit_exp_t x;
      exit_req  = 1'b1;
      exit_slot = 3'd3;
      time_now  = 8'h10;
      exit_q.push_back('{done: 1'b1, err: 1'b0, dur: 8'h20, free: 4'd1});
      tick();
      exit_slot = 3'd5;
      time_now  = 8'h35;
      exit_q.push_back('{done: 1'b1, err: 1'b0, dur: 8'h05, free: 4'd2});
      for (int k = 0; k < 2; k++) begin
         x = exit_q.pop_front();
         compared++;
         if ({exit_done, exit_err} !== {x.done, x.err} || exit_duration !== x.dur) begin
            mismatched++;
            $display("FAIL b2b%0d exit: got done=%b err=%b dur=%h want %b %b %h",
                     k, exit_done, exit_err, exit_duration, x.done, x.err, x.dur);
         end
         compared++;
         if (free_count !== x.free) begin
            mismatched++;
            $display("FAIL b2b%0d free_count: got %0d want %0d", k, free_count, x.free);
         end
         $display("exit b2b%0d done=%b dur=%h free=%0d", k, exit_done, exit_duration, free_count);
         if (k == 0) tick();
         else exit_req = 1'b0;
      end
      tick();
      compared++;
      if (exit_done !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b exit_strobe_len: got %b want 0", exit_done);
      end
      // Slot 5 is now free: exit on it is an error, duration held.
      do_exit("exit5_free", 3'd5, 8'h44, 1'b0, 1'b1, 8'h05, 4'd2);
   endtask

   task automatic test_collision();
      // Free slots are 3 and 5. Exit slot 0 (entered at 8'hED) during CHECK:
      // allocation must take slot 3, not the just-freed slot 0.
      exit_q.push_back('{done: 1'b1, err: 1'b0, dur: 8'h73, free: 4'd2});
      time_now = 8'h58;
      do_entry("collide", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd3, 4'd2, 1'b1, 3'd0, 8'h60);
      do_entry("after_collide0", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd0, 4'd1, 1'b0, 3'd0, 8'h00);
      do_entry("after_collide5", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd5, 4'd0, 1'b0, 3'd0, 8'h00);
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_wrong_token();
      test_round_robin();
      test_full_lot();
      test_back_to_back();
      test_collision();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
